seg7_scan_driver: RTL

Time-multiplexed driver for a 4-digit common-anode seven-segment display. It accepts four packed BCD digits, e.g. from a chain of BCD counters, and latches them tear-free at frame boundaries. It scans one digit at a time at a programmable refresh rate and drives active-low anode, segment and decimal-point pins. It is the display-side consumer of the BCD counter outputs and sits directly on the board I/O.

---
 rtl/seg7_scan_driver.sv | 123 ++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode seven-segment scan driver.
// The shadow register takes new digits at any time; the display register copies it only at frame boundaries.
module seg7_scan_driver #(
    parameter int REFRESH_TICKS = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] digits,
    input  logic        load,
    input  logic        blank_lz,
    input  logic [3:0]  dp_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int TW = (REFRESH_TICKS > 1) ? $clog2(REFRESH_TICKS) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(REFRESH_TICKS - 1);

    logic [TW-1:0] tick_q;
    logic [1:0]    idx_q;
    logic [1:0]    idx_d;
    logic [15:0]   shadow_q;
    logic [15:0]   display_q;
    logic          wrap;
    logic          frame_wrap;
    logic [3:0]    cur_digit;
    logic [3:0]    lz;
    logic [3:0]    an_d;
    logic [6:0]    seg_d;
    logic          dp_d;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    assign wrap       = (tick_q == TICK_MAX);
    assign frame_wrap = wrap && (idx_q == 2'd3);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_q <= '0;
        end else if (wrap) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_q + 1'b1;
        end
    end

    // Scan state register: which digit is currently selected.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q <= 2'd0;
        end else begin
            idx_q <= idx_d;
        end
    end

    always_comb begin
        idx_d = idx_q;
        if (wrap) begin
            idx_d = idx_q + 2'd1;
        end
    end

    // Display copies the pre-edge shadow, so a load on the wrap edge waits one more frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_q  <= 16'h0000;
            display_q <= 16'h0000;
        end else begin
            if (load) begin
                shadow_q <= digits;
            end
            if (frame_wrap) begin
                display_q <= shadow_q;
            end
        end
    end

    always_comb begin
        cur_digit = display_q[{idx_q, 2'b00} +: 4];
        lz[3]     = (display_q[15:12] == 4'd0);
        lz[2]     = lz[3] && (display_q[11:8] == 4'd0);
        lz[1]     = lz[2] && (display_q[7:4] == 4'd0);
        lz[0]     = 1'b0;
        an_d      = ~(4'b0001 << idx_q);
        dp_d      = ~dp_en[idx_q];
        seg_d     = decode(cur_digit);
        if (blank_lz && lz[idx_q]) begin
            seg_d = 7'b1111111;
        end
    end

    // Pins register the decoded view of the current idx, so anode and segments change together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an         <= 4'b1110;
            seg        <= 7'b1000000;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            an         <= an_d;
            seg        <= seg_d;
            dp         <= dp_d;
            frame_done <= frame_wrap;
        end
    end

endmodule
